// File: rtl/lfsr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr_seq : command sequencer driving an external 8-bit LFSR step block   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lfsr_seq #(
  parameter logic [7:0] DEFAULT_TAPS = 8'hB8,
  parameter logic [7:0] DEFAULT_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] state_out,
  output logic       done,
  output logic       err,
  output logic       wrap,
  output logic [7:0] lfsr_in,
  output logic       lfsr_np,
  output logic       lfsr_tap_en,
  output logic [7:0] lfsr_tap_data,
  input  logic [7:0] lfsr_out
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_TAPS = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_LOAD_SEED = 2'b00;
  localparam logic [1:0] OP_LOAD_TAPS = 2'b01;

  logic [2:0] r_fsm;
  logic [2:0] w_fsm_nxt;
  logic [7:0] r_state;
  logic [7:0] r_seed;
  logic [7:0] r_taps;
  logic [8:0] r_cnt;
  logic       r_dir;
  logic       r_err;
  logic       r_wrap;
  logic       w_accept;

  assign w_accept = cmd_valid && (r_fsm == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= S_INIT;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_INIT: w_fsm_nxt = S_IDLE;
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD_SEED: w_fsm_nxt = S_DONE;
            OP_LOAD_TAPS: w_fsm_nxt = S_TAPS;
            default:      w_fsm_nxt = (r_state == 8'h00) ? S_DONE : S_RUN;
          endcase
        end
      end
      S_TAPS: w_fsm_nxt = S_DONE;
      S_RUN:  w_fsm_nxt = (r_cnt == 9'd1) ? S_DONE : S_RUN;
      S_DONE: w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_INIT;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    done          = 1'b0;
    lfsr_tap_en   = 1'b0;
    lfsr_tap_data = r_taps;
    case (r_fsm)
      S_INIT: begin
        lfsr_tap_en   = 1'b1;
        lfsr_tap_data = DEFAULT_TAPS;
      end
      S_IDLE: cmd_ready   = 1'b1;
      S_TAPS: lfsr_tap_en = 1'b1;
      S_DONE: done        = 1'b1;
      default: ;
    endcase
  end

  // Datapath: err/wrap are sticky until the next accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DEFAULT_SEED;
      r_seed  <= DEFAULT_SEED;
      r_taps  <= DEFAULT_TAPS;
      r_cnt   <= 9'd0;
      r_dir   <= 1'b1;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_accept) begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      case (cmd_op)
        OP_LOAD_SEED: begin
          r_state <= cmd_data;
          r_seed  <= cmd_data;
        end
        OP_LOAD_TAPS: r_taps <= cmd_data;
        default: begin
          if (r_state == 8'h00) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= (cmd_data == 8'h00) ? 9'd256 : {1'b0, cmd_data};
            r_dir <= ~cmd_op[0];
          end
        end
      endcase
    end else if (r_fsm == S_RUN) begin
      r_state <= lfsr_out;
      r_cnt   <= r_cnt - 9'd1;
      if (lfsr_out == r_seed) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign state_out = r_state;
  assign lfsr_in   = r_state;
  assign lfsr_np   = r_dir;
  assign err       = r_err;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lfsr_seq : directed bench for lfsr_seq with a Fibonacci step block    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lfsr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] state_out;
  logic       done;
  logic       err;
  logic       wrap;
  logic [7:0] lfsr_in;
  logic       lfsr_np;
  logic       lfsr_tap_en;
  logic [7:0] lfsr_tap_data;
  logic [7:0] lfsr_out;

  always #5 clk = ~clk;

  lfsr_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .state_out(state_out), .done(done),
    .err(err), .wrap(wrap), .lfsr_in(lfsr_in), .lfsr_np(lfsr_np),
    .lfsr_tap_en(lfsr_tap_en), .lfsr_tap_data(lfsr_tap_data), .lfsr_out(lfsr_out)
  );

  // Step block: shift left, feedback parity into bit 0; tap register not reset.
  function automatic logic [7:0] step_fwd(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  function automatic logic [7:0] step_bwd(input logic [7:0] s, input logic [7:0] t);
    return {s[0] ^ (^(s[7:1] & t[6:0])), s[7:1]};
  endfunction

  logic [7:0] m_taps;
  always @(posedge clk) if (lfsr_tap_en) m_taps <= lfsr_tap_data;
  assign lfsr_out = lfsr_np ? step_fwd(lfsr_in, m_taps) : step_bwd(lfsr_in, m_taps);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] st;
    logic       e;
    logic       w;
    int         lat;
  } vec_t;

  vec_t       vecs[19];
  logic [7:0] tr[16];
  int         lat;
  int         npulse;

  // Latency counts cycles from acceptance: done in the cycle right after the
  // accepting edge is latency 1.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                        output int o_lat, output int o_np);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    tr[0] = state_out;
    o_lat = 1;
    o_np  = int'(done);
    if (!done) chk("busy_ready_low", int'(cmd_ready), 0);
    while (!done && o_lat < 300) begin
      @(posedge clk);
      #1;
      if (o_lat < 16) tr[o_lat] = state_out;
      o_lat++;
      o_np += int'(done);
    end
    if (!done) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1 o_np += int'(done);
  endtask

  initial begin
    bit saw_done;
    vecs[0]  = '{2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1};
    vecs[1]  = '{2'd2, 8'h03, 8'h08, 1'b0, 1'b0, 4};
    vecs[2]  = '{2'd3, 8'h03, 8'h01, 1'b0, 1'b1, 4};
    vecs[3]  = '{2'd0, 8'h08, 8'h08, 1'b0, 1'b0, 1};
    vecs[4]  = '{2'd1, 8'h00, 8'h08, 1'b0, 1'b0, 2};
    vecs[5]  = '{2'd2, 8'h01, 8'h10, 1'b0, 1'b0, 2};
    vecs[6]  = '{2'd1, 8'hB8, 8'h10, 1'b0, 1'b0, 2};
    vecs[7]  = '{2'd2, 8'h01, 8'h21, 1'b0, 1'b0, 2};
    vecs[8]  = '{2'd3, 8'h01, 8'h10, 1'b0, 1'b0, 2};
    vecs[9]  = '{2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1};
    vecs[10] = '{2'd2, 8'h05, 8'h00, 1'b1, 1'b0, 1};
    vecs[11] = '{2'd3, 8'h02, 8'h00, 1'b1, 1'b0, 1};
    vecs[12] = '{2'd0, 8'h04, 8'h04, 1'b0, 1'b0, 1};
    vecs[13] = '{2'd2, 8'h01, 8'h08, 1'b0, 1'b0, 2};
    vecs[14] = '{2'd3, 8'h01, 8'h04, 1'b0, 1'b1, 2};
    vecs[15] = '{2'd3, 8'h01, 8'h02, 1'b0, 1'b0, 2};
    vecs[16] = '{2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1};
    vecs[17] = '{2'd2, 8'h00, 8'h02, 1'b0, 1'b1, 257};
    vecs[18] = '{2'd2, 8'h01, 8'h04, 1'b0, 1'b0, 2};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_out), 8'h01);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_wrap", int'({err, wrap}), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("init_tap_en", int'(lfsr_tap_en), 1);
    chk("init_tap_data", int'(lfsr_tap_data), 8'hB8);
    @(posedge clk);
    #1;
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_state", int'(state_out), 8'h01);
    chk("idle_tap_en", int'(lfsr_tap_en), 0);

    for (int i = 0; i < 19; i++) begin
      do_cmd(vecs[i].op, vecs[i].data, lat, npulse);
      chk($sformatf("v%0d_state", i), int'(state_out), int'(vecs[i].st));
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].e));
      chk($sformatf("v%0d_wrap", i), int'(wrap), int'(vecs[i].w));
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_done_pulses", i), npulse, 1);
    end

    // Per-edge state sequences for forward and backward stepping.
    do_cmd(2'd0, 8'h01, lat, npulse);
    do_cmd(2'd2, 8'h03, lat, npulse);
    chk("fwd_seq1", int'(tr[1]), 8'h02);
    chk("fwd_seq2", int'(tr[2]), 8'h04);
    chk("fwd_seq3", int'(tr[3]), 8'h08);
    chk("fwd_np", int'(lfsr_np), 1);
    do_cmd(2'd3, 8'h03, lat, npulse);
    chk("bwd_seq1", int'(tr[1]), 8'h04);
    chk("bwd_seq2", int'(tr[2]), 8'h02);
    chk("bwd_seq3", int'(tr[3]), 8'h01);
    chk("bwd_np_hold", int'(lfsr_np), 0);
    chk("bwd_err", int'(err), 0);

    // Reset mid-RUN with the step block holding non-default taps.
    do_cmd(2'd1, 8'h00, lat, npulse);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_state", int'(state_out), 8'h01);
    chk("abort_ready", int'(cmd_ready), 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 saw_done |= done;
    end
    chk("abort_no_done", int'(saw_done), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("reinit_tap_en", int'(lfsr_tap_en), 1);
    chk("reinit_tap_data", int'(lfsr_tap_data), 8'hB8);
    do_cmd(2'd2, 8'h04, lat, npulse);
    chk("reinit_step_state", int'(state_out), 8'h11);
    chk("reinit_step_latency", lat, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_seq.md
LFSR_SEQ -- requirements
Module: lfsr_seq

Interface
REQ-001 The block SHALL have parameter DEFAULT_TAPS, default 8'hB8, the tap mask loaded into the downstream step block after every reset.
REQ-002 The block SHALL have parameter DEFAULT_SEED, default 8'h01, the reset value of the state and seed registers.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1, command request.
REQ-006 The block SHALL have port cmd_ready, output, 1, high when a command can be accepted.
REQ-007 The block SHALL have port cmd_op, input, 2, command code: 00 LOAD_SEED, 01 LOAD_TAPS, 10 STEP_FWD, 11 STEP_BACK.
REQ-008 The block SHALL have port cmd_data, input, 8, the seed, tap mask or step count, depending on cmd_op.
REQ-009 The block SHALL have port state_out, output, 8, the current LFSR state.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse on command completion.
REQ-011 The block SHALL have port err, output, 1, set by a STEP issued from state 0; cleared on the next accepted command.
REQ-012 The block SHALL have port wrap, output, 1, set when a step produces the stored seed; cleared on the next accepted command.
REQ-013 The block SHALL have port lfsr_in, output, 8, the current state fed to the step block; equals state_out.
REQ-014 The block SHALL have port lfsr_np, output, 1, step direction to the step block: 1 means next, 0 means previous.
REQ-015 The block SHALL have port lfsr_tap_en, output, 1, tap-load strobe to the step block.
REQ-016 The block SHALL have port lfsr_tap_data, output, 8, the tap mask sent to the step block.
REQ-017 The block SHALL have port lfsr_out, input, 8, the one-step result returned by the step block (combinational path).

Function
REQ-018 The FSM SHALL have exactly the states INIT, IDLE, TAPS, RUN and DONE.
REQ-019 INIT SHALL last one cycle, drive lfsr_tap_en=1 and lfsr_tap_data=DEFAULT_TAPS, then go to IDLE.
REQ-020 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-021 cmd_valid SHALL be ignored while cmd_ready=0, and the source SHALL hold the command until it is accepted.
REQ-022 On acceptance of LOAD_SEED, state_q and seed_q SHALL both take cmd_data, and the FSM SHALL go to DONE.
REQ-023 On acceptance of LOAD_TAPS, cmd_data SHALL be latched to tap_q and the FSM SHALL go to TAPS.
REQ-024 TAPS SHALL last one cycle with lfsr_tap_en=1 and lfsr_tap_data=tap_q, then go to DONE.
REQ-025 On acceptance of STEP_FWD or STEP_BACK with state_q!=0, cnt_q SHALL take cmd_data (9-bit; cmd_data 0 means 256), dir_q SHALL take ~cmd_op[0], and the FSM SHALL go to RUN.
REQ-026 On acceptance of a STEP with state_q==0, err SHALL become 1, the state SHALL be left unchanged, and the FSM SHALL go to DONE.
REQ-027 Each RUN cycle SHALL perform state_q<=lfsr_out and cnt_q<=cnt_q-1, with lfsr_np=dir_q throughout RUN.
REQ-028 When lfsr_out==seed_q during RUN, wrap SHALL be set and stepping SHALL continue.
REQ-029 RUN SHALL exit to DONE on the edge where cnt_q==1, so an N-step command applies exactly N updates on N consecutive edges.
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031 The total latency SHALL be: STEP of N accepted at edge k gives done high in the cycle after edge k+N; LOAD_SEED gives done in the cycle after acceptance; LOAD_TAPS gives done 2 cycles after acceptance.
REQ-032 lfsr_tap_en SHALL be 0 in all states other than INIT and TAPS.
REQ-033 Outside RUN, lfsr_np SHALL hold the last dir_q.
REQ-034 No output SHALL depend combinationally on cmd_valid.

Reset
REQ-035 rst=1 SHALL, asynchronously, set the FSM to INIT, state_q and seed_q to DEFAULT_SEED, tap_q to DEFAULT_TAPS, cnt_q to 0, dir_q to 1, and done, err, wrap and cmd_ready to 0.
REQ-036 Reset SHALL abort any in-flight command without producing a done pulse.
REQ-037 The INIT tap reload after reset SHALL be mandatory, because the step block's tap register is not reset.

Verification
REQ-038 Release rst with cmd_valid=0 -> first cycle lfsr_tap_en=1 with lfsr_tap_data=8'hB8; next cycle cmd_ready=1 and state_out=8'h01.
REQ-039 LOAD_SEED 8'h01, then STEP_FWD with cmd_data=3 -> state_out sequence 02,04,08; done pulses once, 4 cycles after the STEP is accepted.
REQ-040 From 8'h08, STEP_BACK with cmd_data=3 -> state_out sequence 04,02,01; err=0.
REQ-041 LOAD_SEED 8'h00, then STEP_FWD with cmd_data=5 -> err=1, state_out stays 8'h00, done pulses 1 cycle after acceptance.
REQ-042 With seed 8'h01 and taps 8'hB8, STEP_FWD with cmd_data=0 -> 256 updates, wrap=1 after the 255th step, final state_out=8'h02.
REQ-043 Assert rst midway through a 10-step RUN -> state_out=8'h01 immediately, no done pulse, and INIT re-drives lfsr_tap_en after rst is released.
